// File: rtl/ram_arbiter_if.sv
// Requester-side bundle for ram_arbiter: two request ports plus the shared
// read-data return. The arbiter connects through the slave modport.
interface ram_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // Handshake: a requester raises reqN with weN/addrN/wdataN valid and keeps
    // req high until ackN pulses for exactly one cycle. The fields are taken
    // once, at grant. A read's rdata is valid in the ack cycle. After ack the
    // requester drops req or re-presents it with a new request; a req seen
    // during its own ack cycle is treated as stale and ignored.
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter driving an asynchronous SRAM through a
// SETUP/WRITE/HOLD write cycle or a SETUP/CAPTURE read cycle.
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_arbiter_if.slave          bus,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_address,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic [2:0]            dbg_state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        WRITE   = 3'd2,
        HOLD    = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  owner_q;
    logic                  last_win_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ack0_q;
    logic                  ack1_q;
    logic                  req0_live;
    logic                  req1_live;
    logic                  contended;
    logic                  pick;
    logic                  take;
    logic                  drive;

    always_comb begin
        req0_live = bus.req0 & ~ack0_q;
        req1_live = bus.req1 & ~ack1_q;
        contended = req0_live & req1_live;
        pick      = contended ? ~last_win_q : req1_live;
        take      = (state == IDLE) && (req0_live || req1_live);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (take) state_next = SETUP;
            SETUP:   state_next = we_q ? WRITE : CAPTURE;
            WRITE:   state_next = HOLD;
            HOLD:    state_next = IDLE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The pointer only moves on a contended grant, so an uncontested grant
    // never costs the other requester its turn at the next collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_q    <= 1'b0;
            last_win_q <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
        end else begin
            state  <= state_next;
            ack0_q <= ((state == HOLD) || (state == CAPTURE)) && !owner_q;
            ack1_q <= ((state == HOLD) || (state == CAPTURE)) && owner_q;
            if (take) begin
                owner_q <= pick;
                we_q    <= pick ? bus.we1 : bus.we0;
                addr_q  <= pick ? bus.addr1 : bus.addr0;
                wdata_q <= pick ? bus.wdata1 : bus.wdata0;
                if (contended) last_win_q <= pick;
            end
            if (state == CAPTURE) rdata_q <= ram_data;
        end
    end

    always_comb begin
        ram_cs = (state != IDLE);
        ram_we = (state == WRITE);
        ram_oe = !we_q && ((state == SETUP) || (state == CAPTURE));
        drive  = we_q && ((state == SETUP) || (state == WRITE) || (state == HOLD));
    end

    assign ram_address = addr_q;
    assign ram_data    = drive ? wdata_q : {DATA_WIDTH{1'bz}};
    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.rdata   = rdata_q;
    assign dbg_state   = state;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: table of single accesses plus hand-written
// contention, back-to-back, mid-operation change and reset-abort sequences.
module tb_ram_arbiter;
    logic        clk;
    logic        rst;
    logic        ram_cs;
    logic        ram_we;
    logic        ram_oe;
    logic [31:0] ram_address;
    wire  [31:0] ram_data;
    logic [2:0]  dbg_state;
    logic [31:0] mem [0:15];
    logic        mem_init;
    logic        mon_en;
    int          n_cmp;
    int          n_fail;

    typedef struct {
        logic        id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    ram_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .ram_oe      (ram_oe),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model; an undriven bus floats to all ones through the pull-ups
    for (genvar gi = 0; gi < 32; gi++) begin : g_pull
        pullup (ram_data[gi]);
    end
    assign ram_data = (ram_cs && ram_oe) ? mem[ram_address[3:0]] : 32'bz;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= {4{i[7:0]}};
        end else if (ram_cs && ram_we) begin
            mem[ram_address[3:0]] <= ram_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bus_checks();
        check("we_oe_exclusive", 32'(ram_we & ram_oe), 32'd0);
        if (!ram_cs) begin
            check("idle_ctrl", 32'({ram_we, ram_oe}), 32'd0);
            check("idle_bus_z", ram_data, 32'hFFFF_FFFF);
        end
    endtask

    task automatic set_req(input logic id, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (id) begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
    endtask

    // driver: one access, latency counted from the cycle the request is presented
    task automatic do_access(input vec_t v);
        int          n;
        int          we_cnt;
        logic        seen;
        logic [31:0] rd;
        @(posedge clk); #1;
        set_req(v.id, 1'b1, v.we, v.addr, v.wdata);
        n = 0; we_cnt = 0; seen = 1'b0; rd = '0;
        while (!seen && n <= 10) begin
            @(negedge clk);
            if (ram_cs) begin
                check("addr_stable", ram_address, v.addr);
                if (ram_we) begin
                    we_cnt++;
                    check("write_data", ram_data, v.wdata);
                end
            end
            check("other_ack_low", 32'(v.id ? bus.ack0 : bus.ack1), 32'd0);
            if (v.id ? bus.ack1 : bus.ack0) begin
                seen = 1'b1;
                rd   = bus.rdata;
                set_req(v.id, 1'b0, v.we, v.addr, v.wdata);
            end else begin
                n++;
            end
        end
        check("ack_seen", 32'(seen), 32'd1);
        check("ack_latency", 32'(n), 32'(v.lat));
        check("rdata", rd, v.exp_rdata);
        if (v.we) begin
            check("we_one_cycle", 32'(we_cnt), 32'd1);
            @(negedge clk);
            check("mem_written", mem[v.addr[3:0]], v.wdata);
        end
    endtask

    // both requesters read (0: addr 1, 1: addr 2) presented in the same cycle
    task automatic contend(input logic first, input logic release_rst);
        int          n;
        int          t0;
        int          t1;
        logic [31:0] r0;
        logic [31:0] r1;
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b0, 32'd1, 32'd0);
        set_req(1'b1, 1'b1, 1'b0, 32'd2, 32'd0);
        if (release_rst) rst = 1'b0;
        n = 0; t0 = -1; t1 = -1; r0 = '0; r1 = '0;
        while ((t0 < 0 || t1 < 0) && n <= 15) begin
            @(negedge clk);
            if (bus.ack0 && t0 < 0) begin
                t0 = n; r0 = bus.rdata; bus.req0 = 1'b0;
            end
            if (bus.ack1 && t1 < 0) begin
                t1 = n; r1 = bus.rdata; bus.req1 = 1'b0;
            end
            n++;
        end
        check("contend_ack0_cycle", 32'(t0), first ? 32'd6 : 32'd3);
        check("contend_ack1_cycle", 32'(t1), first ? 32'd3 : 32'd6);
        check("contend_rdata0", r0, 32'h0101_0101);
        check("contend_rdata1", r1, 32'h0202_0202);
    endtask

    // requester 1 holds req and re-presents addr 10..13 after each ack
    task automatic back_to_back();
        logic [31:0] exp_rd [4];
        int          n;
        int          k;
        exp_rd[0] = 32'h0A0A_0A0A; exp_rd[1] = 32'h0B0B_0B0B;
        exp_rd[2] = 32'h0C0C_0C0C; exp_rd[3] = 32'h0D0D_0D0D;
        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 1'b0, 32'd10, 32'd0);
        n = 0; k = 0;
        while (k < 4 && n <= 25) begin
            @(negedge clk);
            if (bus.ack1) begin
                check("b2b_rdata", bus.rdata, exp_rd[k]);
                // stale req in the ack cycle is ignored, so pulses land 4 apart
                check("b2b_ack_cycle", 32'(n), 32'(3 + 4 * k));
                k++;
                if (k == 4) bus.req1 = 1'b0;
                else        bus.addr1 = 32'(10 + k);
            end
            n++;
        end
        check("b2b_ack_count", 32'(k), 32'd4);
    endtask

    task automatic mid_op_change();
        int   n;
        logic seen;
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b1, 32'd7, 32'h11);
        @(posedge clk); #1;
        check("midop_in_setup", 32'(dbg_state), 32'd1);
        bus.addr0 = 32'd8; bus.wdata0 = 32'h22;
        n = 0; seen = 1'b0;
        while (!seen && n <= 10) begin
            @(negedge clk);
            if (ram_cs) check("midop_addr", ram_address, 32'd7);
            if (bus.ack0) begin
                seen = 1'b1; bus.req0 = 1'b0;
            end
            n++;
        end
        check("midop_ack_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("midop_mem7", mem[7], 32'h11);
        check("midop_mem8", mem[8], 32'h0808_0808);
    endtask

    task automatic reset_mid_write();
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b1, 32'd9, 32'h99);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_in_write", 32'(dbg_state), 32'd2);
        rst = 1'b1; bus.req0 = 1'b0;
        @(posedge clk); #1;
        check("abort_cs", 32'(ram_cs), 32'd0);
        check("abort_we", 32'(ram_we), 32'd0);
        check("abort_oe", 32'(ram_oe), 32'd0);
        check("abort_bus_z", ram_data, 32'hFFFF_FFFF);
        check("abort_address", ram_address, 32'd0);
        check("abort_rdata", bus.rdata, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_ack0", 32'(bus.ack0), 32'd0);
        end
    endtask

    initial begin
        vec_t post;
        rst = 1'b1; mem_init = 1'b1; mon_en = 1'b0;
        n_cmp = 0; n_fail = 0;
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        //            id    we    addr    wdata          lat exp_rdata
        vecs[0] = '{1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 4, 32'h0000_0000};
        vecs[1] = '{1'b0, 1'b0, 32'd5, 32'h0,         3, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 32'd6, 32'hCAFE_F00D, 4, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'd6, 32'h0,         3, 32'hCAFE_F00D};
        vecs[4] = '{1'b0, 1'b0, 32'd3, 32'h0,         3, 32'h0303_0303};
        vecs[5] = '{1'b1, 1'b1, 32'd3, 32'h1234_5678, 4, 32'h0303_0303};
        vecs[6] = '{1'b0, 1'b0, 32'd3, 32'h0,         3, 32'h1234_5678};
        post    = '{1'b1, 1'b0, 32'd5, 32'h0,         3, 32'hDEAD_BEEF};

        @(posedge clk); #1;
        mem_init = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (mon_en) bus_checks();
            end
        join_none
        mon_en = 1'b1;

        @(negedge clk);
        check("rst_ack0", 32'(bus.ack0), 32'd0);
        check("rst_ack1", 32'(bus.ack1), 32'd0);
        check("rst_cs", 32'(ram_cs), 32'd0);
        check("rst_address", ram_address, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) do_access(vecs[i]);

        mid_op_change();

        rst = 1'b1;
        contend(1'b0, 1'b1);
        contend(1'b1, 1'b0);

        back_to_back();
        reset_mid_write();
        do_access(post);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
